// File: rtl/nibble_parity_framer_if.sv
// Nibble stream in, frame parity/count/overflow result out.
// Both sides use a valid/ready handshake.
interface nibble_parity_framer_if #(
    parameter int LEN_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_nibble;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic [LEN_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_nibble, in_last, out_ready,
        input  in_ready, out_valid, out_parity, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_nibble, in_last, out_ready,
        output in_ready, out_valid, out_parity, out_count, out_ovf
    );
endinterface

// File: rtl/nibble_parity_framer.sv
// Frame-level parity accumulator over a nibble stream.
// PARITY_EVEN_EN: invert out_parity (1 on an even count of ones).
module nibble_parity_framer #(
    parameter int LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   aresetn,
    nibble_parity_framer_if.slave  bus
);
`ifdef PARITY_EVEN_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state;
    logic             acc;
    logic [LEN_W-1:0] cnt;
    logic             ovf;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_par_q;
    logic [LEN_W-1:0] out_cnt_q;
    logic             out_ovf_q;

    logic             p;
    logic             accept;
    logic             f_par;
    logic [LEN_W-1:0] f_cnt;
    logic             f_ovf;

    assign p      = ^bus.in_nibble;
    assign accept = bus.in_valid & in_ready_q;

    // Running values after absorbing the current nibble.
    always_comb begin
        f_par = p;
        f_cnt = LEN_W'(1);
        f_ovf = 1'b0;
        if (state == ACC) begin
            f_par = acc ^ p;
            f_ovf = ovf;
            if (&cnt) begin
                f_cnt = cnt;
                f_ovf = 1'b1;
            end else begin
                f_cnt = cnt + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            acc         <= 1'b0;
            cnt         <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_par_q   <= 1'b0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, ACC: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        acc <= f_par;
                        cnt <= f_cnt;
                        ovf <= f_ovf;
                        if (bus.in_last) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_par_q   <= f_par ^ INV;
                            out_cnt_q   <= f_cnt;
                            out_ovf_q   <= f_ovf;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_par_q   <= 1'b0;
                        out_cnt_q   <= '0;
                        out_ovf_q   <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_parity = out_par_q;
    assign bus.out_count  = out_cnt_q;
    assign bus.out_ovf    = out_ovf_q;
endmodule

// File: tb/tb_nibble_parity_framer.sv
// Directed bench for nibble_parity_framer (LEN_W=8 and LEN_W=2).
// Vector table plus reset and overflow sequences.
module tb_nibble_parity_framer;
`ifdef PARITY_EVEN_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    nibble_parity_framer_if #(.LEN_W(8)) bus8 ();
    nibble_parity_framer_if #(.LEN_W(2)) bus2 ();

    nibble_parity_framer #(.LEN_W(8)) dut8 (
        .clk     (clk),
        .aresetn (rst_n),
        .bus     (bus8.slave)
    );

    nibble_parity_framer #(.LEN_W(2)) dut2 (
        .clk     (clk),
        .aresetn (rst_n),
        .bus     (bus2.slave)
    );

    typedef struct {
        logic       v;
        logic [3:0] nib;
        logic       last;
        logic       ordy;
        logic       eir;
        logic       eov;
        logic       epar;
        logic [7:0] ecnt;
        logic       eovf;
    } vec_t;

    vec_t vec [18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic v, input logic [3:0] nib,
                          input logic last, input logic ordy);
        bus8.in_valid  = v;
        bus8.in_nibble = nib;
        bus8.in_last   = last;
        bus8.out_ready = ordy;
    endtask

    task automatic drive2(input logic v, input logic [3:0] nib,
                          input logic last);
        bus2.in_valid  = v;
        bus2.in_nibble = nib;
        bus2.in_last   = last;
    endtask

    task automatic chk8(input string nm, input logic ir, input logic ov,
                        input logic par, input logic [7:0] c,
                        input logic o);
        chk({nm, ".in_ready"}, 32'(bus8.in_ready), 32'(ir));
        chk({nm, ".out_valid"}, 32'(bus8.out_valid), 32'(ov));
        chk({nm, ".out_parity"}, 32'(bus8.out_parity), 32'(par));
        chk({nm, ".out_count"}, 32'(bus8.out_count), 32'(c));
        chk({nm, ".out_ovf"}, 32'(bus8.out_ovf), 32'(o));
    endtask

    task automatic chk2(input string nm, input logic ov, input logic par,
                        input logic [1:0] c, input logic o);
        chk({nm, ".out_valid"}, 32'(bus2.out_valid), 32'(ov));
        chk({nm, ".out_parity"}, 32'(bus2.out_parity), 32'(par));
        chk({nm, ".out_count"}, 32'(bus2.out_count), 32'(c));
        chk({nm, ".out_ovf"}, 32'(bus2.out_ovf), 32'(o));
    endtask

    initial begin
        //        v     nib   last  ordy  ir    ov    par   cnt   ovf
        vec[0]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        vec[1]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        vec[2]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        vec[3]  = '{1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 1'b0};
        vec[4]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        vec[5]  = '{1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0};
        vec[6]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        vec[7]  = '{1'b1, 4'h8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0};
        vec[8]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0};
        vec[9]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0};
        vec[10] = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0};
        vec[11] = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0};
        vec[12] = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0};
        vec[13] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        vec[14] = '{1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        vec[15] = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        vec[16] = '{1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0};
        vec[17] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};

        drive8(1'b0, 4'h0, 1'b0, 1'b1);
        drive2(1'b0, 4'h0, 1'b0);
        bus2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk8("reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("reset.in_ready2", 32'(bus2.in_ready), 32'd0);
        chk2("reset2", 1'b0, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive8(vec[i].v, vec[i].nib, vec[i].last, vec[i].ordy);
            tick();
            chk8($sformatf("vec%0d", i), vec[i].eir, vec[i].eov,
                 vec[i].epar ^ (INV & vec[i].eov), vec[i].ecnt,
                 vec[i].eovf);
        end

        // Saturating overflow on the narrow instance, with bubbles.
        drive2(1'b1, 4'h1, 1'b0); tick();
        drive2(1'b0, 4'h1, 1'b0); tick();
        drive2(1'b1, 4'h1, 1'b0); tick();
        drive2(1'b1, 4'h1, 1'b0); tick();
        drive2(1'b0, 4'h0, 1'b0); tick();
        chk2("ovf.mid", 1'b0, 1'b0, 2'd0, 1'b0);
        drive2(1'b1, 4'h1, 1'b0); tick();
        drive2(1'b1, 4'h1, 1'b1); tick();
        chk2("ovf.done", 1'b1, 1'b1 ^ INV, 2'd3, 1'b1);
        drive2(1'b0, 4'h0, 1'b0); tick();
        chk2("ovf.idle", 1'b0, 1'b0, 2'd0, 1'b0);
        drive2(1'b1, 4'h3, 1'b1); tick();
        chk2("ovf.next", 1'b1, INV, 2'd1, 1'b0);
        drive2(1'b0, 4'h0, 1'b0); tick();

        // Reset in the middle of a frame.
        drive8(1'b1, 4'h1, 1'b0, 1'b1); tick();
        drive8(1'b1, 4'h2, 1'b0, 1'b1); tick();
        drive8(1'b0, 4'h0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk8("rst_mid", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        chk("rst_mid.rel.in_ready", 32'(bus8.in_ready), 32'd1);
        drive8(1'b1, 4'hF, 1'b1, 1'b0); tick();
        chk8("after_rst", 1'b0, 1'b1, INV, 8'd1, 1'b0);

        // Reset while a result is pending.
        drive8(1'b0, 4'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk8("rst_done", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        #2 rst_n = 1'b1;
        bus8.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk8($sformatf("post_rst%0d", k), 1'b1, 1'b0, 1'b0, 8'd0,
                 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_parity_framer.md
# nibble_parity_framer

Frame-level parity accumulator that sits directly upstream of the single-nibble 4-input odd-parity stage and extends its function across whole frames. It accepts a stream of 4-bit nibbles ({a,b,c,d}, bit 3 = a) with a valid/ready handshake. It XOR-reduces every accepted nibble into a running parity bit and counts nibbles per frame. When the frame ends, it presents the frame parity, the nibble count and an overflow flag on a valid/ready result port.

## Interface
- LEN_W, 8: width of the per-frame nibble counter; the count saturates at 2^LEN_W-1.

- clk  in  1  rising-edge clock
- aresetn  in  1  asynchronous, active-low reset
- in_valid  in  1  in_nibble/in_last valid this cycle
- in_ready  out  1  block accepts a nibble this cycle
- in_nibble  in  4  data nibble; bit3=a, bit2=b, bit1=c, bit0=d
- in_last  in  1  accepted nibble is the final one of its frame
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer takes the result this cycle
- out_parity  out  1  frame parity (see Configuration)
- out_count  out  LEN_W  nibbles accepted in the frame, saturating
- out_ovf  out  1  frame exceeded 2^LEN_W-1 nibbles

## Operation
- Accept: in_valid && in_ready on a rising clk edge. Result handshake: out_valid && out_ready.
- Nibble parity: p = in_nibble[3]^in_nibble[2]^in_nibble[1]^in_nibble[0], which is 1 for an odd number of ones.
- FSM states are IDLE, ACC and DONE.
  - IDLE: in_ready=1, out_valid=0. On accept, acc<=p, cnt<=1 and ovf<=0. Go to DONE if in_last, otherwise go to ACC.
  - ACC: in_ready=1, out_valid=0. On accept, acc<=acc^p. If cnt is all-ones, cnt holds and ovf<=1 (sticky); otherwise cnt<=cnt+1. Go to DONE if in_last.
  - DONE: in_ready=0 and out_valid=1. out_parity, out_count and out_ovf are driven from registers and held stable until the result handshake. On the handshake, go to IDLE.
- No accept occurs in DONE, so a new frame can start no earlier than the cycle after the result handshake.
- In IDLE/ACC, in_valid low (bubbles) leaves all state unchanged.
- Zero-length frames do not exist: every frame contains at least the nibble carrying in_last.
- out_parity, out_count and out_ovf are don't-care outside DONE, but the implementation drives 0 there.
- Reset (aresetn low, at any time, including mid-frame or in DONE) immediately clears state to IDLE and acc, cnt and ovf to 0.
  - Outputs during and after reset: in_ready=0 while aresetn is low, then 1 from the first cycle after release. out_valid=0, out_parity=0, out_count=0, out_ovf=0.
  - A partially accumulated frame is discarded and produces no result.

## Timing
- Accept throughput: one nibble per cycle within a frame.
- Latency: out_valid rises in the cycle after the edge that accepts the in_last nibble.
- Minimum frame period: frame length + 1 cycles when out_ready is held high.
- in_ready is a registered function of state only, with no combinational path from in_valid or out_ready.
- out_valid/out_* are registered.
- out_ready may be high before out_valid. The handshake completes on the first edge where both are high.

## Configuration
- Macro PARITY_EVEN_EN.
- Undefined: out_parity = XOR of all bits in the frame, which is 1 when the frame has an odd count of ones. This matches the downstream nibble stage.
- Defined: out_parity is inverted, so it is 1 when the frame has an even count of ones (odd-parity check bit).
- The inversion is applied at the output only. acc, the FSM, and the reset value of out_parity (0) are unchanged.

## Test plan
- Three-nibble frame, macro off: nibbles 0x1, 0x3, 0x7 (last) back-to-back, out_ready=1. Expect out_parity=0, out_count=3, out_ovf=0 one cycle after the last accept, and in_ready=0 for exactly that cycle.
- Single-nibble frame, macro off: 0xB with in_last. Expect out_parity=1, out_count=1. With PARITY_EVEN_EN defined, expect out_parity=0.
- Backpressure: after frame {0x8 last}, hold out_ready=0 for 5 cycles. Expect out_valid=1, out_parity=1 and out_count=1 stable, and in_ready=0 throughout. Raise out_ready: expect IDLE and in_ready=1 the next cycle.
- Overflow with LEN_W=2: five nibbles 0x1, the last with in_last, with in_valid bubbles interleaved. Expect out_count=3, out_ovf=1, out_parity=1.
- Reset mid-frame: accept 0x1 and 0x2, then pulse aresetn low asynchronously between edges. Expect all outputs 0 immediately. After release, frame {0xF last} must give out_parity=0, out_count=1, with no trace of the discarded frame.
- Reset in DONE: assert aresetn while out_valid=1. Expect out_valid to drop at once and no result handshake afterwards.
